mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It sits directly downstream of the EX/MEM pipeline register and consumes its memory-control, address, store-data and destination signals. For each access it runs a req/ready/rvalid handshake with the data-memory bus wrapper, generates byte strobes and aligns load data. It holds the pipeline through the global stall until the access completes. It delivers the extended load word to the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in REQ+WAIT before aborting with bus_err (8-bit counter, range 1..255)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
EX_MEM_memread  input  3  load op: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU (110/111 treated as none)
EX_MEM_memwrite  input  3  store op: 000 none, 001 SB, 010 SH, 011 SW (others treated as none)
EX_MEM_alu_csr_bujrd_data  input  32  effective byte address
EX_MEM_write_data  input  32  store data, right-aligned
dm_req  output  1  bus request
dm_we  output  1  1 = store
dm_addr  output  32  word address {addr[31:2],2'b00}
dm_wstrb  output  4  byte-lane write strobes
dm_wdata  output  32  lane-shifted store data
dm_ready  input  1  request accepted
dm_rvalid  input  1  read data valid
dm_rdata  input  32  read word
lsu_stall  output  1  ORed into stall_CPU
mem_load_data  output  32  sign/zero-extended load result to MEM/WB
misalign_err  output  1  one-cycle pulse, misaligned access dropped
bus_err  output  1  one-cycle pulse, access aborted on timeout

Behaviour:
- Reset (async): state=IDLE, timeout counter=0, captured word=0. All outputs 0: dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, lsu_stall, mem_load_data, misalign_err, bus_err.
- An op is a load if memread ∈ {1..5}, else a store if memwrite ∈ {1..3}. If both are nonzero, load wins.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Valid aligned op: lsu_stall=1 combinationally; go to REQ.
  - Misaligned op: no bus activity, misalign_err=1 for this cycle, lsu_stall=0, mem_load_data=0, stay IDLE.
  - No op: lsu_stall=0.
- REQ:
  - Outputs: dm_req=1, lsu_stall=1. dm_addr, dm_we, dm_wstrb and dm_wdata are driven from the registered op, stable until dm_ready.
  - On dm_ready: store → DONE. Load with dm_rvalid the same cycle → capture dm_rdata, go to DONE. Load otherwise → WAIT.
- WAIT:
  - Outputs: dm_req=0, lsu_stall=1.
  - On dm_rvalid: capture dm_rdata, go to DONE.
- DONE:
  - lsu_stall=0 and mem_load_data is valid for exactly this cycle. EX/MEM advances at the end of DONE.
  - Next state is IDLE. An op present in IDLE on the following cycle is a new instruction. No re-issue occurs because the DONE→IDLE transition is unconditional.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES: go to DONE, pulse bus_err in the DONE cycle, mem_load_data=0.
  - A late dm_rvalid arriving in IDLE is ignored.
- Store strobes:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{wd[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}.
  - SW: wstrb = 1111, wdata = wd.
  - Loads drive wstrb=0000.
- Load extract (DONE only; 0 in all other states):
  - Byte = word[8*addr[1:0] +: 8]; halfword = word[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs cleared. The bus wrapper is reset by the same rst.
- Minimum latency (ready and rvalid immediate): 3 cycles (IDLE, REQ, DONE), with lsu_stall high for 2 cycles.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, dm_ready in first REQ cycle → dm_wstrb=1111, dm_wdata=0xDEADBEEF, dm_addr=0x104, lsu_stall high 2 cycles, no bus_err.
- SB addr 0x203, data 0x000000A5 → dm_wstrb=1000, dm_wdata=0xA5A5A5A5, dm_addr=0x200.
- LB addr 0x302, rdata 0x1280_3456 returned 3 cycles after ready → state passes through WAIT, mem_load_data=0xFFFFFF80 in DONE; LBU same access → 0x00000080.
- LH addr 0x401 → misalign_err pulse, dm_req never asserts, lsu_stall=0, mem_load_data=0.
- LW with dm_ready asserted and dm_rvalid held low, TIMEOUT_CYCLES=4 → DONE after 4 REQ/WAIT cycles, bus_err pulse, mem_load_data=0, then IDLE.
- Back-to-back SW then LHU addr 0x502, rdata 0xBEEF0000 → two separate dm_req episodes, no duplicate store, LHU result 0x0000BEEF. Separately, rst asserted in WAIT → all outputs 0 immediately.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
//   Memory-stage load/store unit. Takes the memory-control, address, store-data
//   signals of the EX/MEM register, runs one req/ready/rvalid handshake per
//   access with the data-memory bus wrapper, builds byte strobes and lane-shifted
//   store data, and returns the sign/zero-extended load word to MEM/WB. The
//   pipeline is held through lsu_stall until the access completes.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent in REQ+WAIT before aborting (1..255)
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   EX_MEM_memread[2:0]         load op  (1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU)
//   EX_MEM_memwrite[2:0]        store op (1 SB, 2 SH, 3 SW)
//   EX_MEM_alu_csr_bujrd_data   effective byte address
//   EX_MEM_write_data           right-aligned store data
//   dm_req/dm_we/dm_addr        bus request, write enable, word address
//   dm_wstrb/dm_wdata           byte-lane strobes, lane-shifted store data
//   dm_ready/dm_rvalid/dm_rdata bus accept, read valid, read word
//   lsu_stall                   pipeline hold, ORed into stall_CPU
//   mem_load_data               extended load result, valid in DONE only
//   misalign_err                one-cycle pulse, misaligned access dropped
//   bus_err                     one-cycle pulse, access aborted on timeout
// -----------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  EX_MEM_memread,
   input  logic [2:0]  EX_MEM_memwrite,
   input  logic [31:0] EX_MEM_alu_csr_bujrd_data,
   input  logic [31:0] EX_MEM_write_data,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_wstrb,
   output logic [31:0] dm_wdata,
   input  logic        dm_ready,
   input  logic        dm_rvalid,
   input  logic [31:0] dm_rdata,
   output logic        lsu_stall,
   output logic [31:0] mem_load_data,
   output logic        misalign_err,
   output logic        bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD}     size_t;

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

   // state and captured access
   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [31:0] r_word;
   logic        r_load;
   size_t       r_size;
   logic        r_sext;
   logic [1:0]  r_boff;
   logic        r_timeout;

   // registered bus outputs
   logic        r_dm_req;
   logic        r_dm_we;
   logic [31:0] r_dm_addr;
   logic [3:0]  r_dm_wstrb;
   logic [31:0] r_dm_wdata;

   // decode of the incoming EX/MEM op
   logic        w_is_load;
   logic        w_is_store;
   size_t       w_size;
   logic        w_sext;
   logic        w_misalign;
   logic        w_issue;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata;

   // timeout and load extraction
   logic [7:0]  w_cnt_nxt;
   logic        w_tmo;
   logic        w_leave_req;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_ext;

   // Load decode takes priority: a nonzero store field is ignored whenever
   // the load field names a valid load.
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_size     = SZ_BYTE;
      w_sext     = 1'b0;
      case (EX_MEM_memread)
         3'd1: begin w_is_load = 1'b1; w_size = SZ_BYTE; w_sext = 1'b1; end
         3'd2: begin w_is_load = 1'b1; w_size = SZ_HALF; w_sext = 1'b1; end
         3'd3: begin w_is_load = 1'b1; w_size = SZ_WORD; end
         3'd4: begin w_is_load = 1'b1; w_size = SZ_BYTE; end
         3'd5: begin w_is_load = 1'b1; w_size = SZ_HALF; end
         default: ;
      endcase
      if (!w_is_load) begin
         case (EX_MEM_memwrite)
            3'd1: begin w_is_store = 1'b1; w_size = SZ_BYTE; end
            3'd2: begin w_is_store = 1'b1; w_size = SZ_HALF; end
            3'd3: begin w_is_store = 1'b1; w_size = SZ_WORD; end
            default: ;
         endcase
      end
   end

   assign w_misalign = ((w_size == SZ_HALF) && EX_MEM_alu_csr_bujrd_data[0]) ||
                       ((w_size == SZ_WORD) && (EX_MEM_alu_csr_bujrd_data[1:0] != 2'b00));
   assign w_issue    = (w_is_load || w_is_store) && !w_misalign;

   // store lane placement; loads drive no strobes
   always_comb begin
      w_wstrb = '0;
      w_wdata = '0;
      if (w_is_store) begin
         case (w_size)
            SZ_BYTE: begin
               w_wstrb = 4'b0001 << EX_MEM_alu_csr_bujrd_data[1:0];
               w_wdata = {4{EX_MEM_write_data[7:0]}};
            end
            SZ_HALF: begin
               w_wstrb = EX_MEM_alu_csr_bujrd_data[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{EX_MEM_write_data[15:0]}};
            end
            default: begin
               w_wstrb = '1;
               w_wdata = EX_MEM_write_data;
            end
         endcase
      end
   end

   assign w_cnt_nxt   = r_cnt + 8'd1;
   assign w_tmo       = (w_cnt_nxt == TMO_LIMIT);
   // bus request fields are dropped once the wrapper accepts or we give up
   assign w_leave_req = (r_state == S_REQ) && (dm_ready || w_tmo);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_word     <= '0;
         r_load     <= 1'b0;
         r_size     <= SZ_BYTE;
         r_sext     <= 1'b0;
         r_boff     <= '0;
         r_timeout  <= 1'b0;
         r_dm_req   <= 1'b0;
         r_dm_we    <= 1'b0;
         r_dm_addr  <= '0;
         r_dm_wstrb <= '0;
         r_dm_wdata <= '0;
      end else begin
         if (w_leave_req) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_wstrb <= '0;
            r_dm_wdata <= '0;
         end
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_state    <= S_REQ;
                  r_cnt      <= '0;
                  r_timeout  <= 1'b0;
                  r_load     <= w_is_load;
                  r_size     <= w_size;
                  r_sext     <= w_sext;
                  r_boff     <= EX_MEM_alu_csr_bujrd_data[1:0];
                  r_dm_req   <= 1'b1;
                  r_dm_we    <= w_is_store;
                  r_dm_addr  <= {EX_MEM_alu_csr_bujrd_data[31:2], 2'b00};
                  r_dm_wstrb <= w_wstrb;
                  r_dm_wdata <= w_wdata;
               end
            end
            S_REQ: begin
               r_cnt <= w_cnt_nxt;
               // completion in the same cycle as the limit wins over timeout
               if (dm_ready) begin
                  if (!r_load) begin
                     r_state <= S_DONE;
                  end else if (dm_rvalid) begin
                     r_word  <= dm_rdata;
                     r_state <= S_DONE;
                  end else if (w_tmo) begin
                     r_timeout <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end else if (w_tmo) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               if (dm_rvalid) begin
                  r_word  <= dm_rdata;
                  r_state <= S_DONE;
               end else if (w_tmo) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // lane extraction from the captured word
   assign w_byte = r_word[{r_boff, 3'b000} +: 8];
   assign w_half = r_word[{r_boff[1], 4'b0000} +: 16];

   always_comb begin
      case (r_size)
         SZ_BYTE: w_load_ext = {{24{r_sext & w_byte[7]}}, w_byte};
         SZ_HALF: w_load_ext = {{16{r_sext & w_half[15]}}, w_half};
         default: w_load_ext = r_word;
      endcase
   end

   assign dm_req        = r_dm_req;
   assign dm_we         = r_dm_we;
   assign dm_addr       = r_dm_addr;
   assign dm_wstrb      = r_dm_wstrb;
   assign dm_wdata      = r_dm_wdata;
   assign mem_load_data = ((r_state == S_DONE) && r_load && !r_timeout) ? w_load_ext : '0;
   assign bus_err       = (r_state == S_DONE) && r_timeout;
   // the IDLE-cycle terms depend on live EX/MEM inputs, so they are masked
   // while reset is held to keep every output at zero
   assign lsu_stall     = !rst && ((r_state == S_REQ) || (r_state == S_WAIT) ||
                                   ((r_state == S_IDLE) && w_issue));
   assign misalign_err  = !rst && (r_state == S_IDLE) &&
                          (w_is_load || w_is_store) && w_misalign;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_lsu
//   Directed and randomized bench for mem_stage_lsu. Each access is described
//   by its op, address, data and bus response delays; expected bus fields,
//   stall profile, timeout outcome and load result are derived arithmetically.
// -----------------------------------------------------------------------------
module tb_mem_stage_lsu;

   localparam int unsigned T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  EX_MEM_memread;
   logic [2:0]  EX_MEM_memwrite;
   logic [31:0] EX_MEM_alu_csr_bujrd_data;
   logic [31:0] EX_MEM_write_data;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_wdata;
   logic        dm_ready;
   logic        dm_rvalid;
   logic [31:0] dm_rdata;
   logic        lsu_stall;
   logic [31:0] mem_load_data;
   logic        misalign_err;
   logic        bus_err;

   int n_chk  = 0;
   int n_pass = 0;
   int n_hs   = 0;

   always #5 clk = ~clk;

   mem_stage_lsu #(.TIMEOUT_CYCLES(T)) dut (
      .clk                       (clk),
      .rst                       (rst),
      .EX_MEM_memread            (EX_MEM_memread),
      .EX_MEM_memwrite           (EX_MEM_memwrite),
      .EX_MEM_alu_csr_bujrd_data (EX_MEM_alu_csr_bujrd_data),
      .EX_MEM_write_data         (EX_MEM_write_data),
      .dm_req                    (dm_req),
      .dm_we                     (dm_we),
      .dm_addr                   (dm_addr),
      .dm_wstrb                  (dm_wstrb),
      .dm_wdata                  (dm_wdata),
      .dm_ready                  (dm_ready),
      .dm_rvalid                 (dm_rvalid),
      .dm_rdata                  (dm_rdata),
      .lsu_stall                 (lsu_stall),
      .mem_load_data             (mem_load_data),
      .misalign_err              (misalign_err),
      .bus_err                   (bus_err)
   );

   // accepted bus requests, used to spot duplicate issues
   always @(posedge clk) if (dm_req && dm_ready) n_hs++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req"},   32'(dm_req),        32'd0);
      chk({tag, "_we"},    32'(dm_we),         32'd0);
      chk({tag, "_addr"},  dm_addr,            32'd0);
      chk({tag, "_wstrb"}, 32'(dm_wstrb),      32'd0);
      chk({tag, "_wdata"}, dm_wdata,           32'd0);
      chk({tag, "_stall"}, 32'(lsu_stall),     32'd0);
      chk({tag, "_ld"},    mem_load_data,      32'd0);
      chk({tag, "_mis"},   32'(misalign_err),  32'd0);
      chk({tag, "_berr"},  32'(bus_err),       32'd0);
   endtask

   task automatic idle();
      EX_MEM_memread  = 3'd0;
      EX_MEM_memwrite = 3'd0;
      dm_ready        = 1'b0;
      dm_rvalid       = 1'b0;
      #1;
      chk("idle_stall", 32'(lsu_stall), 32'd0);
      chk("idle_req",   32'(dm_req),    32'd0);
      @(posedge clk); @(negedge clk);
   endtask

   // One access starting in an IDLE cycle (called at a negedge). rdy = REQ
   // cycle index in which dm_ready is given, rvd = cycles from that point to
   // dm_rvalid (0 = same cycle).
   task automatic do_access(input logic [2:0] mr, input logic [2:0] mw,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int rdy, input int rvd);
      bit          is_ld, is_st, sx, tmo, busreq;
      int          sz, off, cend, nbusy;
      logic [31:0] e_strb, e_wdata, e_ld, v;
      is_ld = (mr >= 3'd1) && (mr <= 3'd5);
      is_st = !is_ld && (mw >= 3'd1) && (mw <= 3'd3);
      sz = 0;
      sx = 1'b0;
      if (is_ld) begin
         sz = (mr == 3'd1 || mr == 3'd4) ? 1 : (mr == 3'd3) ? 4 : 2;
         sx = (mr == 3'd1 || mr == 3'd2);
      end else if (is_st) begin
         sz = (mw == 3'd1) ? 1 : (mw == 3'd2) ? 2 : 4;
      end
      off = int'(addr % 32'd4);

      EX_MEM_memread            = mr;
      EX_MEM_memwrite           = mw;
      EX_MEM_alu_csr_bujrd_data = addr;
      EX_MEM_write_data         = wd;
      dm_ready                  = 1'b0;
      dm_rvalid                 = 1'b0;
      dm_rdata                  = $urandom;
      #1;

      if (sz == 0) begin
         chk("noop_stall", 32'(lsu_stall),    32'd0);
         chk("noop_req",   32'(dm_req),       32'd0);
         chk("noop_mis",   32'(misalign_err), 32'd0);
         @(posedge clk); @(negedge clk);
         return;
      end

      if (off % sz != 0) begin
         chk("mis_err",   32'(misalign_err), 32'd1);
         chk("mis_stall", 32'(lsu_stall),    32'd0);
         chk("mis_req",   32'(dm_req),       32'd0);
         chk("mis_ld",    mem_load_data,     32'd0);
         @(posedge clk); @(negedge clk);
         EX_MEM_memread  = 3'd0;
         EX_MEM_memwrite = 3'd0;
         #1;
         chk("mis_after_req", 32'(dm_req),       32'd0);
         chk("mis_after_err", 32'(misalign_err), 32'd0);
         return;
      end

      chk("issue_stall", 32'(lsu_stall),    32'd1);
      chk("issue_req",   32'(dm_req),       32'd0);
      chk("issue_mis",   32'(misalign_err), 32'd0);

      e_strb  = 32'd0;
      e_wdata = 32'd0;
      if (is_st) begin
         if (sz == 1) begin
            e_strb  = 32'd1 << off;
            e_wdata = (wd & 32'hFF) * 32'h0101_0101;
         end else if (sz == 2) begin
            e_strb  = (off >= 2) ? 32'hC : 32'h3;
            e_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
         end else begin
            e_strb  = 32'hF;
            e_wdata = wd;
         end
      end

      v = rdata >> (8 * off);
      if (sz == 1) begin
         e_ld = v & 32'hFF;
         if (sx && e_ld >= 32'h80) e_ld = e_ld + 32'hFFFF_FF00;
      end else if (sz == 2) begin
         e_ld = v & 32'hFFFF;
         if (sx && e_ld >= 32'h8000) e_ld = e_ld + 32'hFFFF_0000;
      end else begin
         e_ld = rdata;
      end

      cend  = is_st ? rdy : rdy + rvd;
      tmo   = (cend >= int'(T));
      nbusy = tmo ? int'(T) : cend + 1;

      @(posedge clk); @(negedge clk);
      for (int i = 0; i < nbusy; i++) begin
         busreq    = (i <= rdy);
         dm_ready  = (i == rdy);
         dm_rvalid = is_ld && (i == rdy + rvd);
         dm_rdata  = dm_rvalid ? rdata : $urandom;
         #1;
         chk("busy_stall", 32'(lsu_stall), 32'd1);
         chk("busy_req",   32'(dm_req),    32'(busreq));
         if (busreq) begin
            chk("req_addr",  dm_addr,         addr - 32'(off));
            chk("req_we",    32'(dm_we),      32'(is_st));
            chk("req_wstrb", 32'(dm_wstrb),   e_strb);
            chk("req_wdata", dm_wdata,        e_wdata);
         end
         chk("busy_berr", 32'(bus_err),  32'd0);
         chk("busy_ld",   mem_load_data, 32'd0);
         @(posedge clk); @(negedge clk);
      end

      dm_ready  = 1'b0;
      dm_rvalid = 1'b0;
      #1;
      chk("done_stall", 32'(lsu_stall), 32'd0);
      chk("done_req",   32'(dm_req),    32'd0);
      chk("done_berr",  32'(bus_err),   32'(tmo));
      chk("done_ld",    mem_load_data,  (tmo || !is_ld) ? 32'd0 : e_ld);
      @(posedge clk); @(negedge clk);
   endtask

   initial begin
      int hs0;
      rst                       = 1'b1;
      EX_MEM_memread            = 3'd0;
      EX_MEM_memwrite           = 3'd0;
      EX_MEM_alu_csr_bujrd_data = 32'd0;
      EX_MEM_write_data         = 32'd0;
      dm_ready                  = 1'b0;
      dm_rvalid                 = 1'b0;
      dm_rdata                  = 32'd0;
      @(negedge clk); @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      idle();

      // SW aligned, ready in first REQ cycle: minimum latency
      do_access(3'd0, 3'd3, 32'h0000_0104, 32'hDEAD_BEEF, 32'd0, 0, 0);
      // SB to top lane
      do_access(3'd0, 3'd1, 32'h0000_0203, 32'h0000_00A5, 32'd0, 0, 0);
      // LB / LBU with read data three cycles after ready
      do_access(3'd1, 3'd0, 32'h0000_0302, 32'd0, 32'h1280_3456, 0, 3);
      do_access(3'd4, 3'd0, 32'h0000_0302, 32'd0, 32'h1280_3456, 0, 3);
      // misaligned LH dropped
      do_access(3'd2, 3'd0, 32'h0000_0401, 32'd0, 32'd0, 0, 0);
      // LW with rvalid withheld: timeout after T cycles
      do_access(3'd3, 3'd0, 32'h0000_0700, 32'd0, 32'hCAFE_F00D, 0, 100);
      // load and store both present: load wins
      do_access(3'd3, 3'd3, 32'h0000_0800, 32'h1111_2222, 32'h7654_3210, 1, 1);

      // back-to-back SW then LHU: exactly two accepted requests
      hs0 = n_hs;
      do_access(3'd0, 3'd3, 32'h0000_0500, 32'h1122_3344, 32'd0, 1, 0);
      do_access(3'd5, 3'd0, 32'h0000_0502, 32'd0, 32'hBEEF_0000, 0, 0);
      idle();
      chk("hs_count", 32'(n_hs - hs0), 32'd2);

      // reset asserted while waiting for read data
      EX_MEM_memread            = 3'd3;
      EX_MEM_memwrite           = 3'd0;
      EX_MEM_alu_csr_bujrd_data = 32'h0000_0600;
      #1;
      @(posedge clk); @(negedge clk);
      dm_ready = 1'b1;
      #1;
      chk("rw_req", 32'(dm_req), 32'd1);
      @(posedge clk); @(negedge clk);
      dm_ready = 1'b0;
      #1;
      chk("rw_wait_stall", 32'(lsu_stall), 32'd1);
      chk("rw_wait_req",   32'(dm_req),    32'd0);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_wait");
      EX_MEM_memread = 3'd0;
      @(posedge clk); @(negedge clk);
      rst       = 1'b0;
      dm_rvalid = 1'b1;
      dm_rdata  = 32'h55AA_55AA;
      #1;
      chk("late_stall", 32'(lsu_stall), 32'd0);
      chk("late_req",   32'(dm_req),    32'd0);
      @(posedge clk); @(negedge clk);
      dm_rvalid = 1'b0;
      #1;
      chk("late_ld",   mem_load_data, 32'd0);
      chk("late_berr", 32'(bus_err),  32'd0);
      idle();

      // randomized accesses
      for (int k = 0; k < 80; k++) begin
         logic [2:0]  mr, mw;
         logic [31:0] a;
         mr = 3'($urandom_range(0, 7));
         mw = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
         do_access(mr, mw, a, $urandom, $urandom,
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) idle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
